pulse_width_checker: RTL and testbench



---
 rtl/pulse_width_checker_pkg.sv | 30 +++
 rtl/pwc_channel.sv | 147 ++++++++++++++
 rtl/pulse_width_checker.sv | 91 +++++++++
 tb/tb_pulse_width_checker.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_width_checker_pkg.sv
// Shared types and helpers for the pulse width checker.
// The PWC_CAPTURE_EN option is handled in pwc_channel and in the top.
package pulse_width_checker_pkg;

    typedef enum logic [1:0] {
        ARM    = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2,
        OVER   = 2'd3
    } pwc_state_e;

    localparam int DEF_MIN = 2;
    localparam int DEF_MAX = 6;

    // Adds b to a, clamping at lim (lim must be at least a).
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] lim
    );
        logic [32:0] sum_s;
        sum_s = {1'b0, a} + {1'b0, b};
        if (sum_s > {1'b0, lim}) begin
            sat_add = lim;
        end else begin
            sat_add = sum_s[31:0];
        end
    endfunction

endpackage

// File: rtl/pwc_channel.sv
// Single-channel pulse width monitor: arm/idle/active/over FSM and width counter.
// With PWC_CAPTURE_EN defined it also reports the width of the last finished pulse.
module pwc_channel
    import pulse_width_checker_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_i,
    input  logic             en_i,
    input  logic             pol_i,
    input  logic [CNT_W-1:0] min_i,
    input  logic [CNT_W-1:0] max_i,
    output logic             viol_short_o,
    output logic             viol_long_o
`ifdef PWC_CAPTURE_EN
    ,
    output logic [CNT_W-1:0] last_w_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    pwc_state_e       state_r, state_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;
    logic [CNT_W-1:0] lmin_r, lmin_nx_s;
    logic [CNT_W-1:0] lmax_r, lmax_nx_s;
    logic             short_r, short_nx_s;
    logic             long_r, long_nx_s;
    logic [CNT_W:0]   cnt_inc_s;
    logic             act_s;
`ifdef PWC_CAPTURE_EN
    logic [CNT_W-1:0] cap_r, cap_nx_s;
`endif

    assign act_s     = sig_i ~^ pol_i;
    assign cnt_inc_s = {1'b0, cnt_r} + {1'b0, CNT_ONE};

    // Next-state, counter, limit latch and violation decode.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        lmin_nx_s  = lmin_r;
        lmax_nx_s  = lmax_r;
        short_nx_s = 1'b0;
        long_nx_s  = 1'b0;
`ifdef PWC_CAPTURE_EN
        cap_nx_s   = cap_r;
`endif
        if (!en_i) begin
            // Disabled channels sit in ARM so a re-enable never catches a pulse mid-flight.
            state_nx_s = ARM;
        end else begin
            case (state_r)
                ARM: begin
                    if (!act_s) begin
                        state_nx_s = IDLE;
                    end else begin
                        state_nx_s = ARM;
                    end
                end
                IDLE: begin
                    if (act_s) begin
                        state_nx_s = ACTIVE;
                        cnt_nx_s   = CNT_ONE;
                        lmin_nx_s  = min_i;
                        lmax_nx_s  = max_i;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                ACTIVE: begin
                    if (act_s) begin
                        cnt_nx_s = cnt_inc_s[CNT_W-1:0];
                        if (cnt_inc_s > {1'b0, lmax_r}) begin
                            state_nx_s = OVER;
                            long_nx_s  = 1'b1;
                        end else begin
                            state_nx_s = ACTIVE;
                        end
                    end else begin
                        state_nx_s = IDLE;
`ifdef PWC_CAPTURE_EN
                        cap_nx_s   = cnt_r;
`endif
                        if (cnt_r < lmin_r) begin
                            short_nx_s = 1'b1;
                        end else begin
                            short_nx_s = 1'b0;
                        end
                    end
                end
                OVER: begin
                    // cnt already holds lim_max+1 here, which is the saturated width.
                    if (!act_s) begin
                        state_nx_s = IDLE;
`ifdef PWC_CAPTURE_EN
                        cap_nx_s   = cnt_r;
`endif
                    end else begin
                        state_nx_s = OVER;
                    end
                end
                default: begin
                    state_nx_s = ARM;
                end
            endcase
        end
    end

    // State, counter, latched limits and registered violation strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ARM;
            cnt_r   <= '0;
            lmin_r  <= '0;
            lmax_r  <= '0;
            short_r <= 1'b0;
            long_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            lmin_r  <= lmin_nx_s;
            lmax_r  <= lmax_nx_s;
            short_r <= short_nx_s;
            long_r  <= long_nx_s;
        end
    end

`ifdef PWC_CAPTURE_EN
    // Width of the most recent finished pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_r <= '0;
        end else begin
            cap_r <= cap_nx_s;
        end
    end

    assign last_w_o = cap_r;
`endif

    assign viol_short_o = short_r;
    assign viol_long_o  = long_r;

endmodule

// File: rtl/pulse_width_checker.sv
// Multi-channel pulse width checker: per-channel monitors plus sticky status and error count.
// Define PWC_CAPTURE_EN to add last_w_o, the last measured width of each channel.
module pulse_width_checker
    import pulse_width_checker_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int ERR_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       sig_i,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH-1:0]       pol_i,
    input  logic [CNT_W-1:0]        min_i,
    input  logic [CNT_W-1:0]        max_i,
    input  logic                    clr_i,
    output logic [NUM_CH-1:0]       viol_short_o,
    output logic [NUM_CH-1:0]       viol_long_o,
    output logic [NUM_CH-1:0]       sticky_o,
    output logic [ERR_W-1:0]        err_cnt_o
`ifdef PWC_CAPTURE_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] last_w_o
`endif
);

    localparam logic [ERR_W-1:0] ERR_ONES = '1;

    logic [NUM_CH-1:0] viol_any_s;
    logic [NUM_CH-1:0] sticky_r, sticky_nx_s;
    logic [ERR_W-1:0]  err_cnt_r, err_base_s;
    logic [31:0]       pop_s;
    logic [31:0]       err_sum_s;
    logic              unused_err_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwc_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .sig_i        (sig_i[g]),
            .en_i         (en_i[g]),
            .pol_i        (pol_i[g]),
            .min_i        (min_i),
            .max_i        (max_i),
            .viol_short_o (viol_short_o[g]),
            .viol_long_o  (viol_long_o[g])
`ifdef PWC_CAPTURE_EN
            ,
            .last_w_o     (last_w_o[g*CNT_W +: CNT_W])
`endif
        );
    end

    assign viol_any_s = viol_short_o | viol_long_o;

    // Clear drops only the old state, so violations in the clear cycle still land.
    always_comb begin
        pop_s = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop_s = pop_s + {31'd0, viol_any_s[i]};
        end
        if (clr_i) begin
            err_base_s  = '0;
            sticky_nx_s = viol_any_s;
        end else begin
            err_base_s  = err_cnt_r;
            sticky_nx_s = sticky_r | viol_any_s;
        end
        err_sum_s = sat_add(32'(err_base_s), pop_s, 32'(ERR_ONES));
    end

    assign unused_err_s = ^err_sum_s;

    // Sticky status and saturating error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_r  <= '0;
            err_cnt_r <= '0;
        end else begin
            sticky_r  <= sticky_nx_s;
            err_cnt_r <= err_sum_s[ERR_W-1:0];
        end
    end

    assign sticky_o  = sticky_r;
    assign err_cnt_o = err_cnt_r;

endmodule

// File: tb/tb_pulse_width_checker.sv
// Directed self-checking bench for pulse_width_checker (min=2, max=6 baseline).
// last_w_o checks are included when PWC_CAPTURE_EN is defined.
module tb_pulse_width_checker;
    import pulse_width_checker_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int ERR_W  = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH-1:0]       sig;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       pol;
    logic [CNT_W-1:0]        min_v;
    logic [CNT_W-1:0]        max_v;
    logic                    clr;
    logic [NUM_CH-1:0]       viol_short_o;
    logic [NUM_CH-1:0]       viol_long_o;
    logic [NUM_CH-1:0]       sticky_o;
    logic [ERR_W-1:0]        err_cnt_o;
`ifdef PWC_CAPTURE_EN
    logic [NUM_CH*CNT_W-1:0] last_w_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_viol  = 0;
    int v0;

    pulse_width_checker #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W),
        .ERR_W (ERR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sig_i        (sig),
        .en_i         (en),
        .pol_i        (pol),
        .min_i        (min_v),
        .max_i        (max_v),
        .clr_i        (clr),
        .viol_short_o (viol_short_o),
        .viol_long_o  (viol_long_o),
        .sticky_o     (sticky_o),
        .err_cnt_o    (err_cnt_o)
`ifdef PWC_CAPTURE_EN
        ,
        .last_w_o     (last_w_o)
`endif
    );

    always #5 clk = ~clk;

    // Counts every violation strobe bit, sampled mid-cycle.
    always @(negedge clk) n_viol = n_viol + $countones({viol_short_o, viol_long_o});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_act(input int ch, input logic a);
        sig[ch] = a ? pol[ch] : ~pol[ch];
    endtask

    // Active for w samples, then one inactive sample; returns just after that edge.
    task automatic run_pulse(input int ch, input int w);
        set_act(ch, 1'b1);
        repeat (w) tick();
        set_act(ch, 1'b0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        sig   = 4'b0000;
        en    = 4'b0000;
        pol   = 4'b1111;
        min_v = 8'(DEF_MIN);
        max_v = 8'(DEF_MAX);
        clr   = 1'b0;
        repeat (2) tick();
        check("rst_short", 32'(viol_short_o), 32'd0);
        check("rst_long", 32'(viol_long_o), 32'd0);
        check("rst_sticky", 32'(sticky_o), 32'd0);
        check("rst_err", 32'(err_cnt_o), 32'd0);
`ifdef PWC_CAPTURE_EN
        check("rst_lastw", last_w_o, 32'd0);
`endif
        rst_n = 1'b1;
        en    = 4'b1111;
        repeat (2) tick();

        // Boundary widths 2 and 6 are legal.
        v0 = n_viol;
        run_pulse(0, 2);
        run_pulse(0, 6);
        tick();
        check("legal_viol", 32'(n_viol - v0), 32'd0);
        check("legal_err", 32'(err_cnt_o), 32'd0);
`ifdef PWC_CAPTURE_EN
        check("legal_lastw", 32'(last_w_o[7:0]), 32'd6);
`endif

        // Width 1: short strobe for exactly one cycle.
        run_pulse(0, 1);
        check("w1_short", 32'(viol_short_o), 32'h1);
        tick();
        check("w1_short_gone", 32'(viol_short_o), 32'd0);
        check("w1_sticky", 32'(sticky_o), 32'h1);
        check("w1_err", 32'(err_cnt_o), 32'd1);

        // Width 7: long on the 7th active sample, nothing at the fall.
        set_act(0, 1'b1);
        repeat (6) tick();
        check("w7_no_long_yet", 32'(viol_long_o), 32'd0);
        tick();
        check("w7_long", 32'(viol_long_o), 32'h1);
        set_act(0, 1'b0);
        tick();
        check("w7_fall_quiet", 32'({viol_short_o, viol_long_o}), 32'd0);
`ifdef PWC_CAPTURE_EN
        check("w7_lastw", 32'(last_w_o[7:0]), 32'd7);
`endif
        tick();
        check("w7_err", 32'(err_cnt_o), 32'd2);

        // Low-active channel 1, width 3.
        v0 = n_viol;
        pol[1] = 1'b0;
        sig[1] = 1'b1;
        tick();
        run_pulse(1, 3);
        tick();
        check("pol0_viol", 32'(n_viol - v0), 32'd0);
`ifdef PWC_CAPTURE_EN
        check("pol0_lastw", 32'(last_w_o[15:8]), 32'd3);
`endif

        // Enable rises while ch3 is already active for 10 cycles.
        v0 = n_viol;
        en[3] = 1'b0;
        tick();
        set_act(3, 1'b1);
        tick();
        en[3] = 1'b1;
        repeat (10) tick();
        set_act(3, 1'b0);
        repeat (2) tick();
        check("arm_viol", 32'(n_viol - v0), 32'd0);
        check("arm_sticky", 32'(sticky_o), 32'h1);

        // Short on ch3 so sticky has a bit that the clear must drop.
        run_pulse(3, 1);
        tick();
        check("ch3_sticky", 32'(sticky_o), 32'h9);
        check("ch3_err", 32'(err_cnt_o), 32'd3);

        // Same-cycle short ch0 and long ch2, with clear in that cycle.
        set_act(2, 1'b1);
        repeat (5) tick();
        set_act(0, 1'b1);
        tick();
        set_act(0, 1'b0);
        tick();
        check("clr_short", 32'(viol_short_o), 32'h1);
        check("clr_long", 32'(viol_long_o), 32'h4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_err", 32'(err_cnt_o), 32'd2);
        check("clr_sticky", 32'(sticky_o), 32'h5);
        set_act(2, 1'b0);
        tick();
        check("over_fall_quiet", 32'({viol_short_o, viol_long_o}), 32'd0);
`ifdef PWC_CAPTURE_EN
        check("over_lastw", 32'(last_w_o[23:16]), 32'd7);
`endif

        // Limit change mid-pulse uses latched min=2; next pulse sees min=4.
        set_act(0, 1'b1);
        repeat (2) tick();
        min_v = 8'd4;
        tick();
        set_act(0, 1'b0);
        tick();
        check("latched_legal", 32'(viol_short_o), 32'd0);
        run_pulse(0, 3);
        check("new_min_short", 32'(viol_short_o), 32'h1);
        tick();
        check("new_min_err", 32'(err_cnt_o), 32'd3);

        // min > max: width 2 short, width 4 long.
        min_v = 8'd5;
        max_v = 8'd3;
        run_pulse(0, 2);
        check("inv_short", 32'(viol_short_o), 32'h1);
        tick();
        set_act(0, 1'b1);
        repeat (3) tick();
        check("inv_no_long_yet", 32'(viol_long_o), 32'd0);
        tick();
        check("inv_long", 32'(viol_long_o), 32'h1);
        set_act(0, 1'b0);
        repeat (2) tick();
        check("inv_err", 32'(err_cnt_o), 32'd5);

        // min = 0 disables the short check.
        min_v = 8'd0;
        max_v = 8'd6;
        run_pulse(0, 1);
        check("min0_short", 32'(viol_short_o), 32'd0);
        tick();
        check("min0_err", 32'(err_cnt_o), 32'd5);
        min_v = 8'd2;

        // Reset mid-pulse; the remainder (long enough to be a violation) is ignored.
        v0 = n_viol;
        set_act(0, 1'b1);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_sticky", 32'(sticky_o), 32'd0);
        check("midrst_err", 32'(err_cnt_o), 32'd0);
        check("midrst_viol", 32'({viol_short_o, viol_long_o}), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        set_act(0, 1'b0);
        repeat (2) tick();
        check("postrst_viol", 32'(n_viol - v0), 32'd0);
        check("postrst_err", 32'(err_cnt_o), 32'd0);
        check("postrst_sticky", 32'(sticky_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
